// File: rtl/stream_width_downsizer.sv
// Serializes one IN_WIDTH word into 1..RATIO OUT_WIDTH beats; beat 0 is presented the cycle after load.
// Stalls hold all outputs; a new word loads only when idle or alongside the current word's last beat.
module stream_width_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int RATIO = IN_WIDTH / OUT_WIDTH,
  localparam int CNT_W = $clog2(RATIO + 1),
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [CNT_W-1:0]     in_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [IDX_W-1:0]     out_idx
);

  logic                r_busy;
  logic [IN_WIDTH-1:0] r_sh;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_len;

  logic                w_busy_nxt;
  logic [IN_WIDTH-1:0] w_sh_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CNT_W-1:0]    w_len_nxt;
  logic                w_load;
  logic                w_beat;
  logic [CNT_W-1:0]    w_len_eff;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_sh   <= '0;
      r_idx  <= '0;
      r_len  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_sh   <= w_sh_nxt;
      r_idx  <= w_idx_nxt;
      r_len  <= w_len_nxt;
    end
  end

  // Next-state: a load wins over retiring the last beat, so words run back-to-back.
  always_comb begin
    w_load     = in_valid && in_ready;
    w_beat     = r_busy && out_ready;
    w_len_eff  = ((in_len == '0) || (in_len > CNT_W'(RATIO))) ? CNT_W'(RATIO) : in_len;
    w_busy_nxt = r_busy;
    w_sh_nxt   = r_sh;
    w_idx_nxt  = r_idx;
    w_len_nxt  = r_len;
    if (w_load) begin
      w_busy_nxt = 1'b1;
      w_sh_nxt   = in_data;
      w_idx_nxt  = '0;
      w_len_nxt  = w_len_eff;
    end else if (w_beat) begin
      if (out_last) begin
        w_busy_nxt = 1'b0;
      end else begin
        w_sh_nxt  = MSB_FIRST ? (r_sh << OUT_WIDTH) : (r_sh >> OUT_WIDTH);
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end
  end

  // Outputs; in_ready is combinational from out_ready.
  always_comb begin
    out_valid = r_busy;
    out_idx   = r_idx;
    out_last  = r_busy && (CNT_W'(r_idx) == (r_len - CNT_W'(1)));
    in_ready  = !r_busy || (out_ready && out_last);
    out_data  = MSB_FIRST ? r_sh[IN_WIDTH-1 -: OUT_WIDTH] : r_sh[OUT_WIDTH-1:0];
  end

endmodule

// File: tb/tb_stream_width_downsizer.sv
// Directed checks for stream_width_downsizer: per-cycle vector table plus MSB-first, backpressure and reset sequences.
module tb_stream_width_downsizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        out_ready;
  logic        l_in_ready, l_out_valid, l_out_last;
  logic [7:0]  l_out_data;
  logic [1:0]  l_out_idx;
  logic        m_in_ready, m_out_valid, m_out_last;
  logic [7:0]  m_out_data;
  logic [1:0]  m_out_idx;

  int total = 0;
  int bad   = 0;

  stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .in_len(in_len), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_data(l_out_data), .out_last(l_out_last), .out_idx(l_out_idx)
  );

  stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_len(in_len), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_data(m_out_data), .out_last(m_out_last), .out_idx(m_out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [2:0]  len;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_dat;
    logic [1:0]  e_idx;
    logic        e_last;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic iv, input logic [31:0] d, input logic [2:0] len, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_dat,
                     input logic [1:0] e_idx, input logic e_last);
    vec_t v;
    v.iv = iv; v.d = d; v.len = len; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_dat = e_dat; v.e_idx = e_idx; v.e_last = e_last;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [2:0] len, input logic ordy);
    in_valid = iv; in_data = d; in_len = len; out_ready = ordy;
  endtask

  initial begin
    bit done;
    logic [7:0] beats [4];
    int k;
    int cyc;

    drive(1'b0, 32'h0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("rst_out_valid", {31'b0, l_out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, l_in_ready},  32'd1);
    chk("rst_out_last",  {31'b0, l_out_last},  32'd0);
    chk("rst_out_idx",   {30'b0, l_out_idx},   32'd0);
    chk("rst_out_data",  {24'b0, l_out_data},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full word
    add(1'b1, 32'hDDCCBBAA, 3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'hAA, 2'd0, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'hBB, 2'd1, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'hCC, 2'd2, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 8'hDD, 2'd3, 1'b1);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    // back-to-back words
    add(1'b1, 32'h04030201, 3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    add(1'b1, 32'h08070605, 3'd4, 1'b1, 1'b0, 1'b1, 8'h01, 2'd0, 1'b0);
    add(1'b1, 32'h08070605, 3'd4, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1, 1'b0);
    add(1'b1, 32'h08070605, 3'd4, 1'b1, 1'b0, 1'b1, 8'h03, 2'd2, 1'b0);
    add(1'b1, 32'h08070605, 3'd4, 1'b1, 1'b1, 1'b1, 8'h04, 2'd3, 1'b1);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h05, 2'd0, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h06, 2'd1, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h07, 2'd2, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 8'h08, 2'd3, 1'b1);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    // partial length 2, then len=0 and len=7 clamped to 4
    add(1'b1, 32'h11223344, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h44, 2'd0, 1'b0);
    add(1'b1, 32'h55667788, 3'd0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1, 1'b1);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h88, 2'd0, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h77, 2'd1, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'h66, 2'd2, 1'b0);
    add(1'b1, 32'h99AABBCC, 3'd7, 1'b1, 1'b1, 1'b1, 8'h55, 2'd3, 1'b1);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'hCC, 2'd0, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'hBB, 2'd1, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 8'hAA, 2'd2, 1'b0);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 8'h99, 2'd3, 1'b1);
    add(1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);

    foreach (tv[i]) begin
      drive(tv[i].iv, tv[i].d, tv[i].len, tv[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i),  {31'b0, l_in_ready},  {31'b0, tv[i].e_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, l_out_valid}, {31'b0, tv[i].e_ov});
      chk($sformatf("vec%0d_out_last", i),  {31'b0, l_out_last},  {31'b0, tv[i].e_last});
      if (tv[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), {24'b0, l_out_data}, {24'b0, tv[i].e_dat});
        chk($sformatf("vec%0d_out_idx", i),  {30'b0, l_out_idx},  {30'b0, tv[i].e_idx});
      end
      @(negedge clk);
    end

    // MSB-first, len 3
    drive(1'b1, 32'hDDCCBBAA, 3'd3, 1'b1);
    #1 chk("msb_load_in_ready", {31'b0, m_in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'd0, 1'b1);
    beats[0] = 8'hDD; beats[1] = 8'hCC; beats[2] = 8'hBB;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk($sformatf("msb_b%0d_data", b), {24'b0, m_out_data}, {24'b0, beats[b]});
      chk($sformatf("msb_b%0d_idx", b),  {30'b0, m_out_idx},  b);
      chk($sformatf("msb_b%0d_last", b), {31'b0, m_out_last}, (b == 2) ? 32'd1 : 32'd0);
      chk($sformatf("msb_b%0d_in_ready", b), {31'b0, m_in_ready}, (b == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    #1 chk("msb_idle_out_valid", {31'b0, m_out_valid}, 32'd0);
    @(negedge clk);

    // random backpressure on a full word
    drive(1'b1, 32'hDDCCBBAA, 3'd4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    beats[0] = 8'hAA; beats[1] = 8'hBB; beats[2] = 8'hCC; beats[3] = 8'hDD;
    k = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("bp_c%0d_valid", cyc), {31'b0, l_out_valid}, 32'd1);
      chk($sformatf("bp_c%0d_data", cyc),  {24'b0, l_out_data}, {24'b0, beats[k]});
      chk($sformatf("bp_c%0d_idx", cyc),   {30'b0, l_out_idx},  k);
      chk($sformatf("bp_c%0d_last", cyc),  {31'b0, l_out_last}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("bp_c%0d_in_ready", cyc), {31'b0, l_in_ready},
          (out_ready && k == 3) ? 32'd1 : 32'd0);
      if (out_ready) begin
        if (k == 3) done = 1'b1;
        else k++;
      end
      cyc++;
      @(negedge clk);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL bp_timeout: got %0d beats accepted expected 4", k);
    end
    out_ready = 1'b1;
    #1 chk("bp_idle_out_valid", {31'b0, l_out_valid}, 32'd0);
    @(negedge clk);

    // async reset mid-word after beat 0 accepted
    drive(1'b1, 32'hDDCCBBAA, 3'd4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("mid_pre_rst_data", {24'b0, l_out_data}, 32'h000000BB);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, l_out_valid}, 32'd0);
    chk("mid_rst_out_idx",   {30'b0, l_out_idx},   32'd0);
    chk("mid_rst_out_data",  {24'b0, l_out_data},  32'd0);
    chk("mid_rst_out_last",  {31'b0, l_out_last},  32'd0);
    chk("mid_rst_in_ready",  {31'b0, l_in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0D0C0B0A, 3'd4, 1'b1);
    #1 chk("post_rst_in_ready", {31'b0, l_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_b0_data", {24'b0, l_out_data}, 32'h0000000A);
    chk("post_rst_b0_idx",  {30'b0, l_out_idx},  32'd0);
    chk("post_rst_b0_valid", {31'b0, l_out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
